fwrisc_trace_ctrl: RTL and testbench
====================================

Name: fwrisc_trace_ctrl

Overview:
Trigger-based trace capture controller fed by the core's execute-stage trace signals (pc, instr, ivalid). It keeps a circular history of retired instructions and freezes capture a programmable number of instructions after a PC-match trigger. A debug host then drains the history oldest-first over a valid/ready port. The block sits alongside the core's tracer attachment point and sequences the shared trace buffer between capture and readout.

Parameters:
DEPTH, 16, number of trace entries; power of two, minimum 2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clock  input  1  core clock.
reset  input  1  asynchronous, active-high reset.
pc  input  32  PC of instruction in execute.
instr  input  32  instruction word in execute.
ivalid  input  1  execute stage valid; one retired instruction per asserted cycle.
trig_en  input  1  enables PC-match trigger.
trig_pc  input  32  trigger PC.
post_count  input  PTR_W+1  entries to capture after the trigger entry; values above DEPTH-1 are clamped to DEPTH-1.
arm  input  1  single-cycle pulse: clear buffer, enter ARMED.
stop  input  1  single-cycle pulse: force DONE.
out_valid  output  1  oldest entry available (DONE only).
out_ready  input  1  host accepts the entry.
out_data  output  64  {pc, instr} of the oldest entry; 0 when out_valid=0.
count  output  PTR_W+1  valid entries held, 0..DEPTH.
state  output  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
triggered  output  1  set when the trigger fired since the last arm.

Behaviour:
- Reset (async): state=IDLE, wr_ptr=rd_ptr=0, count=0, triggered=0, out_valid=0, out_data=0. Buffer contents don't care.
- IDLE: no capture. arm -> ARMED with the buffer cleared. stop is ignored.
- ARMED: each ivalid cycle writes {pc,instr} at wr_ptr and increments wr_ptr (mod DEPTH).
  - If count<DEPTH, count increments.
  - If count==DEPTH, the oldest entry is overwritten: rd_ptr increments and count stays at DEPTH.
- Trigger: in ARMED, when ivalid && trig_en && pc==trig_pc:
  - The trigger instruction is captured in that cycle and triggered is set to 1.
  - Next state is DONE if clamped post_count==0; otherwise POST with remaining=post_count.
- POST: captures exactly as in ARMED, including overwrite when full. Each ivalid decrements remaining. The capture that brings remaining to 0 moves the block to DONE on the next cycle. A further trig_pc match is ignored.
- DONE: no capture.
  - out_valid = (count!=0); out_data = mem[rd_ptr].
  - On out_valid && out_ready: rd_ptr increments and count decrements in that cycle.
  - The block stays in DONE when empty.
- stop in ARMED or POST: if ivalid is also high, that cycle's instruction is captured; then the block enters DONE. triggered is unchanged.
- arm in any state (including mid-POST or mid-drain): next cycle state=ARMED, pointers=0, count=0, triggered=0. arm has priority over stop, trigger and drain in the same cycle, and the concurrent ivalid is not captured.
- No combinational path from out_ready to out_valid. out_data may be a combinational read of the memory at rd_ptr.
- post_count is sampled at the trigger cycle; later changes have no effect.

Test Plan:
- DEPTH=4, reset; arm; 3 ivalid at pc=0x100,0x104,0x108; stop -> DONE, count=3; drain with out_ready=1 yields 0x100,0x104,0x108 in 3 consecutive cycles, then out_valid=0, count=0.
- Wrap/overwrite: arm, 6 ivalid pc=0x0..0x14 step 4, stop -> count=4, drain 0x8,0xC,0x10,0x14.
- Trigger: trig_en=1, trig_pc=0x200, post_count=2; pcs 0x1F8,0x1FC,0x200,0x204,0x208,0x20C -> DONE after 0x208, triggered=1, count=4, drain 0x1FC,0x200,0x204,0x208; 0x20C absent.
- post_count=0, trigger at pc=0x40 -> DONE next cycle, last drained entry pc=0x40; post_count=7 (DEPTH=4) is clamped to 3.
- Drain backpressure: out_ready toggles 1,0,1 -> entries pop only on ready cycles, order preserved, out_data stable while out_ready=0.
- arm asserted mid-POST together with ivalid and stop -> next cycle state=ARMED, count=0, triggered=0, concurrent instruction not captured; async reset mid-drain -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fwrisc_trace_ctrl.sv
// Trigger-based trace capture: circular history of retired instructions,
// frozen a programmable distance after a PC match, then drained oldest-first.
module fwrisc_trace_ctrl #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             ivalid,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  input  logic [PTR_W:0]   post_count,
  input  logic             arm,
  input  logic             stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [PTR_W:0]   count,
  output logic [1:0]       state,
  output logic             triggered
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [63:0]      r_mem [DEPTH];
  state_t           r_state, w_state_n;
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_n;
  logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_n;
  logic [PTR_W:0]   r_count, w_count_n;
  logic [PTR_W-1:0] r_remaining, w_remaining_n;
  logic             r_trig, w_trig_n;
  logic             w_capture, w_pop, w_hit, w_full, w_out_valid;
  logic [PTR_W-1:0] w_post_clamped;

  always_comb begin
    w_state_n     = r_state;
    w_wr_ptr_n    = r_wr_ptr;
    w_rd_ptr_n    = r_rd_ptr;
    w_count_n     = r_count;
    w_remaining_n = r_remaining;
    w_trig_n      = r_trig;
    w_capture     = 1'b0;
    w_pop         = 1'b0;
    w_hit         = ivalid && trig_en && (pc == trig_pc);
    // DEPTH is a power of two, so any value with the top bit set exceeds DEPTH-1
    w_post_clamped = post_count[PTR_W] ? '1 : post_count[PTR_W-1:0];
    w_full        = (r_count == CNT_FULL);
    w_out_valid   = (r_state == S_DONE) && (r_count != '0);

    if (arm) begin
      w_state_n     = S_ARMED;
      w_wr_ptr_n    = '0;
      w_rd_ptr_n    = '0;
      w_count_n     = '0;
      w_remaining_n = '0;
      w_trig_n      = 1'b0;
    end else begin
      case (r_state)
        S_ARMED: begin
          w_capture = ivalid;
          if (w_hit) begin
            w_trig_n      = 1'b1;
            w_remaining_n = w_post_clamped;
            w_state_n     = (w_post_clamped == '0) ? S_DONE : S_POST;
          end
          if (stop) w_state_n = S_DONE;
        end
        S_POST: begin
          w_capture = ivalid;
          if (ivalid) begin
            w_remaining_n = r_remaining - PTR_ONE;
            if (r_remaining == PTR_ONE) w_state_n = S_DONE;
          end
          if (stop) w_state_n = S_DONE;
        end
        S_DONE:  w_pop = w_out_valid && out_ready;
        default: ;
      endcase

      if (w_capture) begin
        w_wr_ptr_n = r_wr_ptr + PTR_ONE;
        if (w_full) w_rd_ptr_n = r_rd_ptr + PTR_ONE;
        else        w_count_n  = r_count + CNT_ONE;
      end
      if (w_pop) begin
        w_rd_ptr_n = r_rd_ptr + PTR_ONE;
        w_count_n  = r_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_trig      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_count     <= w_count_n;
      r_remaining <= w_remaining_n;
      r_trig      <= w_trig_n;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) r_mem[r_wr_ptr] <= {pc, instr};
  end

  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign state     = r_state;
  assign triggered = r_trig;

endmodule

// File: tb/tb_fwrisc_trace_ctrl.sv
// Directed bench for fwrisc_trace_ctrl with DEPTH=4; instr is always pc+0x1000.
module tb_fwrisc_trace_ctrl;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      pc = '0;
  logic [31:0]      instr = '0;
  logic             ivalid = 1'b0;
  logic             trig_en = 1'b0;
  logic [31:0]      trig_pc = '0;
  logic [PTR_W:0]   post_count = '0;
  logic             arm = 1'b0;
  logic             stop = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_data;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  logic             triggered;

  int total = 0;
  int bad   = 0;

  fwrisc_trace_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instr(instr), .ivalid(ivalid),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_count(post_count),
    .arm(arm), .stop(stop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .state(state), .triggered(triggered)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] expd(input logic [31:0] p);
    return {p, p + 32'h1000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic cap(input logic [31:0] p);
    ivalid = 1'b1; pc = p; instr = p + 32'h1000;
    tick();
    ivalid = 1'b0;
  endtask

  // Check the head entry, then pop it; out_ready stays high so calls chain back-to-back.
  task automatic drain1(input string tag, input logic [31:0] p);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, expd(p));
    out_ready = 1'b1;
    tick();
  endtask

  task automatic chk_empty(input string tag);
    out_ready = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    tick(); tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_trig", 64'(triggered), 64'd0);
    reset = 1'b0;
    tick();

    do_stop();
    chk("idle_stop_ignored", 64'(state), 64'd0);
    cap(32'h100);
    chk("idle_no_capture", 64'(count), 64'd0);

    // Basic capture and drain
    do_arm();
    chk("arm_state", 64'(state), 64'd1);
    cap(32'h100); cap(32'h104); cap(32'h108);
    chk("basic_count_armed", 64'(count), 64'd3);
    do_stop();
    chk("basic_state", 64'(state), 64'd3);
    chk("basic_count", 64'(count), 64'd3);
    chk("basic_trig", 64'(triggered), 64'd0);
    drain1("basic0", 32'h100);
    drain1("basic1", 32'h104);
    drain1("basic2", 32'h108);
    chk_empty("basic_end");
    chk("basic_stay_done", 64'(state), 64'd3);

    // Wrap / overwrite
    do_arm();
    chk("wrap_cleared", 64'(count), 64'd0);
    for (int i = 0; i < 6; i++) cap(32'(i * 4));
    do_stop();
    chk("wrap_count", 64'(count), 64'd4);
    drain1("wrap0", 32'h8);
    drain1("wrap1", 32'hC);
    drain1("wrap2", 32'h10);
    drain1("wrap3", 32'h14);
    chk_empty("wrap_end");

    // Trigger with post_count=2
    trig_en = 1'b1; trig_pc = 32'h200; post_count = 3'd2;
    do_arm();
    cap(32'h1F8); cap(32'h1FC);
    chk("trig_not_yet", 64'(triggered), 64'd0);
    cap(32'h200);
    chk("trig_post_state", 64'(state), 64'd2);
    chk("trig_flag", 64'(triggered), 64'd1);
    post_count = 3'd0;
    cap(32'h204);
    chk("trig_post_still", 64'(state), 64'd2);
    cap(32'h208);
    chk("trig_done_state", 64'(state), 64'd3);
    cap(32'h20C);
    chk("trig_count", 64'(count), 64'd4);
    chk("trig_flag_done", 64'(triggered), 64'd1);
    drain1("trig0", 32'h1FC);
    drain1("trig1", 32'h200);
    drain1("trig2", 32'h204);
    drain1("trig3", 32'h208);
    chk_empty("trig_end");

    // post_count=0: DONE right after the trigger entry
    trig_pc = 32'h40; post_count = 3'd0;
    do_arm();
    cap(32'h3C); cap(32'h40);
    chk("pc0_state", 64'(state), 64'd3);
    cap(32'h44);
    chk("pc0_count", 64'(count), 64'd2);
    drain1("pc0_0", 32'h3C);
    drain1("pc0_1", 32'h40);
    chk_empty("pc0_end");

    // post_count=7 clamps to 3
    trig_pc = 32'h80; post_count = 3'd7;
    do_arm();
    cap(32'h80); cap(32'h84); cap(32'h88);
    chk("clamp_still_post", 64'(state), 64'd2);
    cap(32'h8C);
    chk("clamp_done", 64'(state), 64'd3);
    chk("clamp_count", 64'(count), 64'd4);
    drain1("clamp0", 32'h80);
    drain1("clamp1", 32'h84);
    drain1("clamp2", 32'h88);
    drain1("clamp3", 32'h8C);
    chk_empty("clamp_end");
    trig_en = 1'b0;

    // Backpressure: ready 1,0,1
    do_arm();
    cap(32'h300); cap(32'h304); cap(32'h308);
    do_stop();
    drain1("bp0", 32'h300);
    out_ready = 1'b0;
    chk("bp_hold_data_a", out_data, expd(32'h304));
    tick();
    chk("bp_hold_data_b", out_data, expd(32'h304));
    chk("bp_hold_count", 64'(count), 64'd2);
    drain1("bp1", 32'h304);
    chk("bp_count_after", 64'(count), 64'd1);
    drain1("bp2", 32'h308);
    chk_empty("bp_end");

    // arm together with ivalid and stop mid-POST
    trig_en = 1'b1; trig_pc = 32'h500; post_count = 3'd3;
    do_arm();
    cap(32'h500); cap(32'h504);
    chk("mid_post_state", 64'(state), 64'd2);
    arm = 1'b1; stop = 1'b1; ivalid = 1'b1; pc = 32'h508; instr = 32'h1508;
    tick();
    arm = 1'b0; stop = 1'b0; ivalid = 1'b0;
    chk("rearm_state", 64'(state), 64'd1);
    chk("rearm_count", 64'(count), 64'd0);
    chk("rearm_trig", 64'(triggered), 64'd0);
    do_stop();
    chk("rearm_done", 64'(state), 64'd3);
    chk_empty("rearm_empty");
    trig_en = 1'b0;

    // Async reset mid-drain
    do_arm();
    cap(32'h600); cap(32'h604);
    do_stop();
    drain1("ar0", 32'h600);
    out_ready = 1'b0;
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("ar_state", 64'(state), 64'd0);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_data", out_data, 64'd0);
    chk("ar_trig", 64'(triggered), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_idle_after", 64'(state), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
